// File: rtl/pulse_stretch_gen_if.sv
// rtl/pulse_stretch_gen_if.sv - request and strobe bundle for pulse_stretch_gen
interface pulse_stretch_gen_if #(
   parameter int PEND_W = 3
) ();
   logic              trig_in;
   logic              clr;
   logic              level_out;
   logic              done;
   logic              busy;
   logic [PEND_W-1:0] pend_cnt;
   logic              overflow;

   modport master (
      output trig_in, clr,
      input  level_out, done, busy, pend_cnt, overflow
   );

   modport slave (
      input  trig_in, clr,
      output level_out, done, busy, pend_cnt, overflow
   );
endinterface

// File: rtl/pulse_stretch_gen.sv
// rtl/pulse_stretch_gen.sv - one-cycle event to fixed-width level pulse with queued replay
module pulse_stretch_gen #(
   parameter int PULSE_WIDTH = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int PEND_W      = 3
) (
   input logic                ACLK,
   input logic                ARESETN,
   pulse_stretch_gen_if.slave sif
);
   localparam int MAX_DUR = (PULSE_WIDTH > GAP_CYCLES) ? PULSE_WIDTH : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_DUR) + 1;

   // Counters hold "cycles remaining minus one", so zero marks the last cycle of a phase.
   localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              level_q, level_d;
   logic              done_q, done_d;
   logic              last_cycle;
   logic              q_inc;
   logic              q_dec;

   assign last_cycle = (cnt_q == '0);

   // Next state, phase counter, pending queue and sticky overflow.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      level_d = 1'b0;
      q_inc   = 1'b0;
      q_dec   = 1'b0;

      case (state_q)
         IDLE: begin
            // Accepted directly; an idle request never touches the queue.
            if (sif.trig_in) begin
               state_d = HIGH;
               cnt_d   = HIGH_LOAD;
            end
         end
         HIGH: begin
            q_inc = sif.trig_in;
            if (last_cycle) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (last_cycle) begin
               if (pend_q != '0) begin
                  // Replay the oldest queued request; a new trigger takes its slot.
                  state_d = HIGH;
                  cnt_d   = HIGH_LOAD;
                  q_dec   = 1'b1;
                  q_inc   = sif.trig_in;
               end else if (sif.trig_in) begin
                  state_d = HIGH;
                  cnt_d   = HIGH_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               q_inc = sif.trig_in;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (q_dec && !q_inc) begin
         pend_d = pend_q - 1'b1;
      end else if (q_inc && !q_dec) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end

      // Clear wins over everything, including a trigger in the same cycle.
      if (sif.clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = '0;
         ovf_d   = 1'b0;
         done_d  = 1'b0;
      end

      // Output level is registered from the next state, so it is high exactly in HIGH.
      level_d = (state_d == HIGH);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         level_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         level_q <= level_d;
         done_q  <= done_d;
      end
   end

   assign sif.level_out = level_q;
   assign sif.done      = done_q;
   assign sif.busy      = (state_q != IDLE) || (pend_q != '0);
   assign sif.pend_cnt  = pend_q;
   assign sif.overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretch_gen.sv
// tb/tb_pulse_stretch_gen.sv - bench for pulse_stretch_gen
module tb_pulse_stretch_gen;
   localparam int PW     = 4;
   localparam int GAP    = 2;
   localparam int PEND_W = 2;
   localparam int PMAX   = 3;

   logic ACLK;
   logic ARESETN;

   pulse_stretch_gen_if #(.PEND_W(PEND_W)) bus ();

   pulse_stretch_gen #(
      .PULSE_WIDTH (PW),
      .GAP_CYCLES  (GAP),
      .PEND_W      (PEND_W)
   ) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .sif     (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference: an active pulse is described by the cycle its high phase starts.
   bit m_active;
   int m_start;
   int m_pend;
   bit m_ovf;

   logic [255:0] h_lvl, h_done, h_busy, h_ovf, h_pnz;
   int           h_pend[256];

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_active = 1'b0;
      m_start  = 0;
      m_pend   = 0;
      m_ovf    = 1'b0;
   endfunction

   // Effect of the inputs seen during cycle cyc on cycle cyc+1.
   function automatic void model_step(input logic t, input logic c);
      int k;
      if (c) begin
         model_reset();
         return;
      end
      if (!m_active) begin
         if (t) begin
            m_active = 1'b1;
            m_start  = cyc + 1;
         end
         return;
      end
      k = cyc - m_start;
      if (k == PW + GAP - 1) begin
         if (m_pend > 0) begin
            m_start = cyc + 1;
            if (!t) m_pend--;
         end else if (t) begin
            m_start = cyc + 1;
         end else begin
            m_active = 1'b0;
         end
      end else if (t) begin
         if (m_pend == PMAX) m_ovf = 1'b1;
         else m_pend++;
      end
   endfunction

   function automatic logic e_level();
      return m_active && ((cyc - m_start) < PW);
   endfunction

   function automatic logic e_done();
      return m_active && ((cyc - m_start) == PW);
   endfunction

   function automatic logic e_busy();
      return m_active || (m_pend != 0);
   endfunction

   function automatic void clear_hist();
      h_lvl  = '0;
      h_done = '0;
      h_busy = '0;
      h_ovf  = '0;
      h_pnz  = '0;
      for (int i = 0; i < 256; i++) h_pend[i] = 0;
   endfunction

   function automatic int count_pulses();
      int n = 0;
      for (int i = 1; i < 64; i++) if (h_lvl[i] && !h_lvl[i-1]) n++;
      return n;
   endfunction

   task automatic tick(input logic t, input logic c);
      bus.trig_in = t;
      bus.clr     = c;
      @(posedge ACLK);
      if (ARESETN) model_step(t, c);
      cyc++;
      #1;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      cyc = 0;
      clear_hist();
   endtask

   task automatic do_reset();
      bus.trig_in = 1'b0;
      bus.clr     = 1'b0;
      ARESETN     = 1'b0;
      model_reset();
      release_reset();
   endtask

   // Per-cycle comparison against the reference, also recording history.
   initial begin
      forever begin
         @(negedge ACLK);
         if (cyc < 256) begin
            h_lvl[cyc]  = bus.level_out;
            h_done[cyc] = bus.done;
            h_busy[cyc] = bus.busy;
            h_ovf[cyc]  = bus.overflow;
            h_pnz[cyc]  = (bus.pend_cnt != '0);
            h_pend[cyc] = int'(bus.pend_cnt);
         end
         check("level_out", 64'(bus.level_out), 64'(e_level()));
         check("done",      64'(bus.done),      64'(e_done()));
         check("busy",      64'(bus.busy),      64'(e_busy()));
         check("pend_cnt",  64'(bus.pend_cnt),  64'(m_pend));
         check("overflow",  64'(bus.overflow),  64'(m_ovf));
      end
   end

   initial begin
      logic [63:0] ovf_exp;
      int          dens[4];
      int          p;

      dens = '{5, 25, 60, 95};
      p    = 25;
      bus.trig_in = 1'b0;
      bus.clr     = 1'b0;
      do_reset();
      check("rst_state", 64'({bus.level_out, bus.done, bus.busy, bus.pend_cnt, bus.overflow}), 64'd0);

      // Single request.
      for (int c = 0; c <= 24; c++) tick(c == 10, 1'b0);
      check("t1_level", 64'(h_lvl[31:0]),  64'h0000_7800);
      check("t1_done",  64'(h_done[31:0]), 64'h0000_8000);
      check("t1_busy",  64'(h_busy[31:0]), 64'h0001_F800);
      check("t1_pend",  64'(h_pnz[31:0]),  64'h0);

      // Second request queued during the first pulse.
      do_reset();
      for (int c = 0; c <= 30; c++) tick(c == 10 || c == 12, 1'b0);
      check("t2_level",  64'(h_lvl[31:0]),  64'h001E_7800);
      check("t2_done",   64'(h_done[31:0]), 64'h0020_8000);
      check("t2_busy",   64'(h_busy[31:0]), 64'h007F_F800);
      check("t2_pnz",    64'(h_pnz[31:0]),  64'h0001_E000);
      check("t2_pend13", 64'(h_pend[13]),   64'd1);

      // Held trigger saturates the queue.
      do_reset();
      for (int c = 0; c <= 50; c++) tick(c >= 10 && c <= 17, 1'b0);
      ovf_exp = ((64'd1 << 51) - 64'd1) & ~((64'd1 << 15) - 64'd1);
      check("t3_level",   h_lvl[63:0],           64'h0000_0079_E79E_7800);
      check("t3_pulses",  64'(count_pulses()),   64'd5);
      check("t3_pend13",  64'(h_pend[13]),       64'd2);
      check("t3_pend14",  64'(h_pend[14]),       64'd3);
      check("t3_pend34",  64'(h_pend[34]),       64'd1);
      check("t3_pend35",  64'(h_pend[35]),       64'd0);
      check("t3_ovf",     64'(h_ovf[50:0]),      ovf_exp);
      check("t3_busy40",  64'(h_busy[40]),       64'd1);
      check("t3_busy41",  64'(h_busy[41]),       64'd0);

      // Clear aborts a pulse without done.
      do_reset();
      for (int c = 0; c <= 30; c++) tick(c == 10 || c == 15, c == 12);
      check("t4_level",  64'(h_lvl[31:0]),  64'h000F_1800);
      check("t4_done",   64'(h_done[31:0]), 64'h0010_0000);
      check("t4_busy13", 64'(h_busy[13]),   64'd0);
      check("t4_pend13", 64'(h_pend[13]),   64'd0);

      // Asynchronous reset mid-pulse with a non-empty queue and overflow set.
      do_reset();
      for (int c = 0; c <= 11; c++) tick(c >= 4 && c <= 8, 1'b0);
      #2;
      check("t5_pre", 64'({bus.level_out, bus.busy, bus.overflow, bus.pend_cnt}), 64'b11110);
      ARESETN = 1'b0;
      model_reset();
      #1;
      check("t5_post", 64'({bus.level_out, bus.done, bus.busy, bus.overflow, bus.pend_cnt}), 64'd0);
      release_reset();
      for (int c = 0; c <= 24; c++) tick(c == 10, 1'b0);
      check("t5_level", 64'(h_lvl[31:0]),  64'h0000_7800);
      check("t5_done",  64'(h_done[31:0]), 64'h0000_8000);

      // Direct accept on the last gap cycle.
      do_reset();
      for (int c = 0; c <= 30; c++) tick(c == 10 || c == 16, 1'b0);
      check("t6_level", 64'(h_lvl[31:0]),  64'h001E_7800);
      check("t6_done",  64'(h_done[31:0]), 64'h0020_8000);
      check("t6_pnz",   64'(h_pnz[31:0]),  64'h0);

      // Random traffic with varying density, occasional clear and reset.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) p = dens[$urandom_range(0, 3)];
         if (n % 750 == 749) do_reset();
         tick($urandom_range(0, 99) < p, $urandom_range(0, 63) == 0);
      end
      tick(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
